uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//  Buffered 8N1 serial port for the memory-mapped hardware register block.
//  - TX side: a byte FIFO that a bus-side write strobe fills; a serialiser drains it onto UART_TX.
//  - RX side: a deserialiser on UART_RX fills a byte FIFO that a bus-side read strobe pops.
//  - Exposes TX free-slot count and RX head byte / not-empty for status/data registers.
// PARAMETERS
//  CLKS_PER_BIT  434  clock cycles per serial bit (50 MHz / 115200 baud)
//  DEPTH         512  entries per FIFO (power of two); slots-free count is 10 bits
// PORTS
//  clock          in   1   single clock, all logic rising-edge
//  reset          in   1   asynchronous, active-low reset
//  UART_RX        in   1   serial input, idle high, asynchronous to clock
//  UART_TX        out  1   serial output, idle high
//  tx_write       in   1   push tx_wdata into TX FIFO (one-cycle strobe)
//  tx_wdata       in   8   byte to transmit
//  tx_slots_free  out  10  DEPTH minus TX FIFO occupancy
//  rx_read        in   1   pop RX FIFO head (one-cycle strobe)
//  rx_rdata       out  8   RX FIFO head byte, first-word-fall-through
//  rx_not_empty   out  1   RX FIFO holds at least one byte
// BEHAVIOUR
//  Reset values:
//  - UART_TX=1, both FIFOs empty, tx_slots_free=DEPTH, rx_not_empty=0, rx_rdata=0.
//  - Both serial FSMs go to IDLE; a reset mid-frame abandons the frame.
//  FIFO rules (both FIFOs):
//  - Occupancy count 0..DEPTH; pointers wrap modulo DEPTH.
//  - Push when full: byte dropped, no state change.
//  - Pop when empty: ignored.
//  - Push+pop same cycle, non-empty: both happen, count unchanged.
//  - Push+pop same cycle, empty: push only.
//  - Head data is valid while not-empty, before the pop strobe (FWFT).
//  - After a pop, the next byte is presented on the following cycle.
//  TX FSM (IDLE, START, DATA, STOP):
//  - IDLE: when TX FIFO non-empty, latch head byte, go to START.
//  - Line levels: START drives 0; DATA drives bits 0..7 LSB first; STOP drives 1; every bit lasts CLKS_PER_BIT.
//  - End of STOP: pop TX FIFO (one-cycle pulse), return to IDLE.
//  - Back-to-back bytes: no extra idle beyond one clock.
//  - Latency: tx_write at edge N -> UART_TX low from edge N+2.
//  - tx_slots_free counts the in-flight byte as occupied until its stop bit ends.
//  RX FSM (IDLE, START, DATA, STOP):
//  - UART_RX passes through a 2-flop synchroniser.
//  - IDLE: a sampled 0 moves to START.
//  - START: at CLKS_PER_BIT/2 re-sample; if 1, treat as a glitch and return to IDLE.
//  - DATA: sample 8 bits every CLKS_PER_BIT at mid-bit, LSB first.
//  - STOP: sample the stop bit at mid-bit. If 1, push the byte into the RX FIFO (one-cycle strobe). If 0 (framing error), discard the byte.
//  - Return to IDLE only once the line is high; a byte arriving while RX FIFO is full is dropped.
//  - rx_read concurrent with an RX push obeys the FIFO rules above.
// TESTING
//  1. Reset, tx_write 0x55 -> UART_TX 0, then 1,0,1,0,1,0,1,0, then 1, each 434 clocks; slots_free 511 -> 512.
//  2. Write 0x41,0x42,0x43 in consecutive cycles -> slots_free 509; three frames back-to-back in order; slots_free ends 512.
//  3. Drive frame 0xA3 on UART_RX -> rx_not_empty=1 and rx_rdata=0xA3 after stop mid-bit; rx_read -> rx_not_empty=0.
//  4. Frame with stop bit 0 -> no push; 200-clock low glitch -> no push; both leave RX FSM in IDLE.
//  5. 513 writes with TX held in reset-free flow -> slots_free floors at 0; extra byte dropped; pop on empty RX is ignored.
//  6. Assert reset mid TX frame -> UART_TX=1 immediately; FIFOs empty; slots_free=512.

Source files
------------

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: buffered 8N1 UART with first-word-fall-through TX and RX byte FIFOs
module uart_fifo_buf #(
  parameter int DEPTH = 512,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        push,
  input  logic [7:0]  wdata,
  input  logic        pop,
  output logic [7:0]  head,
  output logic [AW:0] count
);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && count != FULL;
  assign do_pop = pop && count != '0;
  // head reads as zero while empty so the data register never shows stale bytes
  assign head = count != '0 ? mem[rd_ptr] : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  always_ff @(posedge clock)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

module uart_fifo_core #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DEPTH = 512
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     UART_RX,
  output logic                     UART_TX,
  input  logic                     tx_write,
  input  logic [7:0]               tx_wdata,
  output logic [$clog2(DEPTH):0]   tx_slots_free,
  input  logic                     rx_read,
  output logic [7:0]               rx_rdata,
  output logic                     rx_not_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t tx_state, rx_state;
  logic [7:0] tx_head, tx_sh, rx_sh;
  logic [AW:0] tx_count, rx_count;
  logic [CW-1:0] tx_cnt, rx_cnt;
  logic [2:0] tx_bit, rx_bit;
  logic tx_pop, rx_s1, rx_s2, rx_hold, rx_push;

  uart_fifo_buf #(.DEPTH(DEPTH)) tx_fifo (
    .clock(clock), .reset(reset), .push(tx_write), .wdata(tx_wdata),
    .pop(tx_pop), .head(tx_head), .count(tx_count)
  );

  uart_fifo_buf #(.DEPTH(DEPTH)) rx_fifo (
    .clock(clock), .reset(reset), .push(rx_push), .wdata(rx_sh),
    .pop(rx_read), .head(rx_rdata), .count(rx_count)
  );

  // the in-flight byte stays in the FIFO until its stop bit has gone out
  assign tx_pop = tx_state == STOP && tx_cnt == LAST;
  assign tx_slots_free = FULL - tx_count;
  assign rx_not_empty = rx_count != '0;

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      tx_state <= IDLE;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh <= '0;
      UART_TX <= 1'b1;
    end else begin
      UART_TX <= tx_state == START ? 1'b0 : tx_state == DATA ? tx_sh[0] : 1'b1;
      tx_cnt <= tx_state == IDLE || tx_cnt == LAST ? '0 : tx_cnt + 1'b1;
      case (tx_state)
        IDLE: if (tx_count != '0) begin
          tx_sh <= tx_head;
          tx_state <= START;
        end
        START: if (tx_cnt == LAST) begin
          tx_bit <= '0;
          tx_state <= DATA;
        end
        DATA: if (tx_cnt == LAST) begin
          tx_sh <= tx_sh >> 1;
          tx_bit <= tx_bit + 1'b1;
          if (tx_bit == 3'd7) tx_state <= STOP;
        end
        STOP: if (tx_cnt == LAST) tx_state <= IDLE;
        default: tx_state <= IDLE;
      endcase
    end

  // rx_hold parks the FSM after the stop sample until the line is idle again
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_state <= IDLE;
      rx_cnt <= '0;
      rx_bit <= '0;
      rx_sh <= '0;
      rx_hold <= 1'b0;
      rx_push <= 1'b0;
    end else begin
      rx_s1 <= UART_RX;
      rx_s2 <= rx_s1;
      rx_push <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_cnt <= '0;
          if (!rx_s2) rx_state <= START;
        end
        START: if (rx_cnt == HALF) begin
          rx_cnt <= '0;
          rx_bit <= '0;
          rx_state <= rx_s2 ? IDLE : DATA;
        end else rx_cnt <= rx_cnt + 1'b1;
        DATA: if (rx_cnt == LAST) begin
          rx_cnt <= '0;
          rx_sh <= {rx_s2, rx_sh[7:1]};
          rx_bit <= rx_bit + 1'b1;
          if (rx_bit == 3'd7) rx_state <= STOP;
        end else rx_cnt <= rx_cnt + 1'b1;
        STOP: if (rx_hold) begin
          if (rx_s2) begin
            rx_hold <= 1'b0;
            rx_state <= IDLE;
          end
        end else if (rx_cnt == LAST) begin
          rx_push <= rx_s2;
          rx_hold <= 1'b1;
        end else rx_cnt <= rx_cnt + 1'b1;
        default: rx_state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_fifo_core.sv
// tb_uart_fifo_core: directed stimulus with queued expectations checked by TX and RX monitors
module tb_uart_fifo_core;
  localparam int CPB = 434;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic UART_RX = 1'b1;
  logic UART_TX;
  logic tx_write = 1'b0;
  logic [7:0] tx_wdata = 8'h00;
  logic [9:0] tx_slots_free;
  logic rx_read = 1'b0;
  logic [7:0] rx_rdata;
  logic rx_not_empty;
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int n;
  logic lvl;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  int tx_starts[$];
  logic [9:0] mon_bits;
  bit mon_ok;
  int mon_t0;

  uart_fifo_core dut (
    .clock(clock), .reset(reset), .UART_RX(UART_RX), .UART_TX(UART_TX),
    .tx_write(tx_write), .tx_wdata(tx_wdata), .tx_slots_free(tx_slots_free),
    .rx_read(rx_read), .rx_rdata(rx_rdata), .rx_not_empty(rx_not_empty)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic wait_clk(input int k);
    repeat (k) @(negedge clock);
  endtask

  task automatic write_tx(input logic [7:0] b, input bit accepted);
    tx_wdata = b;
    tx_write = 1'b1;
    if (accepted) tx_q.push_back(b);
    @(negedge clock);
    tx_write = 1'b0;
  endtask

  task automatic send_rx(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (stop) rx_q.push_back(b);
    for (int i = 0; i < 10; i++) begin
      UART_RX = f[i];
      wait_clk(CPB);
    end
  endtask

  task automatic read_rx;
    rx_read = 1'b1;
    @(negedge clock);
    rx_read = 1'b0;
  endtask

  // decode each TX frame at mid-bit and compare against the queued byte
  always begin
    @(negedge clock);
    if (reset && UART_TX == 1'b0) begin
      mon_ok = 1'b1;
      mon_t0 = cyc;
      for (int k = 0; k < 10 && mon_ok; k++) begin
        for (int j = 0; j < (k == 0 ? CPB / 2 - 1 : CPB) && mon_ok; j++) begin
          @(negedge clock);
          if (!reset) mon_ok = 1'b0;
        end
        mon_bits[k] = UART_TX;
      end
      if (mon_ok) begin
        check("tx_start_bit", int'(mon_bits[0]), 0);
        check("tx_stop_bit", int'(mon_bits[9]), 1);
        if (tx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_frame: got unexpected byte 0x%02h, expected no frame", mon_bits[8:1]);
        end else check("tx_byte", int'(mon_bits[8:1]), int'(tx_q.pop_front()));
        tx_starts.push_back(mon_t0);
      end
    end
  end

  // every accepted RX pop must present the next queued byte
  always @(negedge clock) begin
    #1;
    if (reset && rx_read && rx_not_empty) begin
      if (rx_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_pop: got unexpected byte 0x%02h, expected empty", rx_rdata);
      end else check("rx_byte", int'(rx_rdata), int'(rx_q.pop_front()));
    end
  end

  initial begin
    wait_clk(3);
    check("rst_tx", int'(UART_TX), 1);
    check("rst_slots", int'(tx_slots_free), 512);
    check("rst_ne", int'(rx_not_empty), 0);
    check("rst_rdata", int'(rx_rdata), 0);
    reset = 1'b1;
    wait_clk(2);
    // single byte: latency, exact bit lengths, slot release at end of stop
    write_tx(8'h55, 1'b1);
    check("lat_n", int'(UART_TX), 1);
    check("slots_511", int'(tx_slots_free), 511);
    @(negedge clock);
    check("lat_n1", int'(UART_TX), 1);
    @(negedge clock);
    check("lat_n2", int'(UART_TX), 0);
    lvl = 1'b0;
    for (int r = 0; r < 9; r++) begin
      n = 0;
      while (UART_TX == lvl && n < 1000) begin
        n++;
        @(negedge clock);
      end
      check($sformatf("run%0d_len", r), n, CPB);
      lvl = ~lvl;
    end
    check("stop_level", int'(UART_TX), 1);
    wait_clk(430);
    check("slots_in_stop", int'(tx_slots_free), 511);
    wait_clk(6);
    check("slots_after_stop", int'(tx_slots_free), 512);
    // three back-to-back bytes
    wait_clk(20);
    tx_starts.delete();
    write_tx(8'h41, 1'b1);
    write_tx(8'h42, 1'b1);
    write_tx(8'h43, 1'b1);
    check("slots_509", int'(tx_slots_free), 509);
    n = 0;
    while (tx_slots_free != 10'd512 && n < 15000) begin
      n++;
      @(negedge clock);
    end
    check("drain_512", int'(tx_slots_free), 512);
    wait_clk(5);
    check("frames3", tx_starts.size(), 3);
    if (tx_starts.size() >= 3) begin
      check("gap1", tx_starts[1] - tx_starts[0], 10 * CPB + 1);
      check("gap2", tx_starts[2] - tx_starts[1], 10 * CPB + 1);
    end
    check("txq_empty2", tx_q.size(), 0);
    // good RX frame
    send_rx(8'hA3, 1'b1);
    check("rx_ne_a3", int'(rx_not_empty), 1);
    check("rx_head_a3", int'(rx_rdata), 'hA3);
    read_rx();
    check("rx_ne_after_read", int'(rx_not_empty), 0);
    check("rx_rdata_empty", int'(rx_rdata), 0);
    wait_clk(100);
    // framing error then short glitch, neither may push
    send_rx(8'h3C, 1'b0);
    UART_RX = 1'b1;
    wait_clk(CPB);
    check("rx_ferr", int'(rx_not_empty), 0);
    UART_RX = 1'b0;
    wait_clk(200);
    UART_RX = 1'b1;
    wait_clk(2 * CPB);
    check("rx_glitch", int'(rx_not_empty), 0);
    send_rx(8'h96, 1'b1);
    check("rx_ne_96", int'(rx_not_empty), 1);
    read_rx();
    check("rx_ne_96_read", int'(rx_not_empty), 0);
    // pop on empty RX, then fill TX beyond capacity
    read_rx();
    check("rx_pop_empty_ne", int'(rx_not_empty), 0);
    check("rx_pop_empty_data", int'(rx_rdata), 0);
    for (int i = 0; i < 513; i++) write_tx(8'(i), i < 512);
    check("slots_full", int'(tx_slots_free), 0);
    wait_clk(3);
    check("slots_full_hold", int'(tx_slots_free), 0);
    send_rx(8'h5A, 1'b1);
    send_rx(8'hC3, 1'b1);
    check("rx_two_ne", int'(rx_not_empty), 1);
    read_rx();
    check("rx_second_head", int'(rx_rdata), 'hC3);
    read_rx();
    check("rx_two_drained", int'(rx_not_empty), 0);
    // reset in the middle of a TX frame
    n = 0;
    while (UART_TX == 1'b0 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    n = 0;
    while (UART_TX == 1'b1 && n < 5000) begin
      n++;
      @(negedge clock);
    end
    wait_clk(10);
    check("pre_reset_low", int'(UART_TX), 0);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", int'(UART_TX), 1);
    check("mid_rst_slots", int'(tx_slots_free), 512);
    check("mid_rst_ne", int'(rx_not_empty), 0);
    check("mid_rst_rdata", int'(rx_rdata), 0);
    tx_q.delete();
    wait_clk(3);
    reset = 1'b1;
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clock);
      if (UART_TX == 1'b0) n++;
    end
    check("post_rst_idle", n, 0);
    check("post_rst_slots", int'(tx_slots_free), 512);
    check("txq_final", tx_q.size(), 0);
    check("rxq_final", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
